// File: rtl/window_queue_mc.sv
// rtl/window_queue_mc.sv - multi-channel decimating sliding-window sample queue
//
// Stores every DECIM-th strobed sample of all channels in a shared circular
// buffer. Once WINDOW samples are held, each accepted write triggers a burst
// that replays the WINDOW most recent samples, oldest first, one per clock.
//
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   new_smpl     packed input samples, channel 0 in the LSBs
//   valid_rise   one-cycle strobe qualifying new_smpl
//   flush        synchronous clear of pointers, counters, flags and burst state
//   smpl_out     window sample (packed like new_smpl), zero when not valid
//   smpl_vld     smpl_out carries a window sample this cycle
//   sequencing   burst in progress (address cycle plus streaming cycles)
//   seq_done     pulse with the last sample of a burst
//   full         WINDOW samples accepted since reset or flush
//   overrun      sticky: a trigger arrived while one was already pending
module window_queue_mc #(
    parameter int WIDTH    = 16,
    parameter int CHANNELS = 2,
    parameter int ADDR_W   = 10,
    parameter int WINDOW   = 1021,
    parameter int DECIM    = 2
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [CHANNELS*WIDTH-1:0] new_smpl,
    input  logic                      valid_rise,
    input  logic                      flush,
    output logic [CHANNELS*WIDTH-1:0] smpl_out,
    output logic                      smpl_vld,
    output logic                      sequencing,
    output logic                      seq_done,
    output logic                      full,
    output logic                      overrun
);

    localparam int DW    = CHANNELS * WIDTH;
    localparam int DEPTH = 1 << ADDR_W;
    localparam int DEC_W = (DECIM > 1) ? $clog2(DECIM) : 1;

    localparam logic [ADDR_W-1:0] WIN_A    = ADDR_W'(WINDOW);
    localparam logic [ADDR_W-1:0] WIN_M1   = ADDR_W'(WINDOW - 1);
    localparam logic [ADDR_W-1:0] ONE_A    = ADDR_W'(1);
    localparam logic [DEC_W-1:0]  DEC_LAST = DEC_W'(DECIM - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ADDR,
        S_STREAM
    } state_t;

    state_t              state;
    state_t              state_nxt;
    logic [DW-1:0]       mem [DEPTH];
    logic [DW-1:0]       rd_data;
    logic [ADDR_W-1:0]   wr_ptr;
    logic [ADDR_W-1:0]   fill_cnt;
    logic [ADDR_W-1:0]   start_ptr;
    logic [ADDR_W-1:0]   rd_addr;
    logic [ADDR_W-1:0]   rd_sel;
    logic [ADDR_W-1:0]   beat_cnt;
    logic [DEC_W-1:0]    dec_cnt;
    logic                pending;
    logic                pend_nxt;
    logic                ovr_set;
    logic                full_q;
    logic                overrun_q;
    logic                wrt_en;
    logic                trigger;
    logic                last_beat;

    // flush wins over a coincident strobe, so the sample is simply dropped
    assign wrt_en    = valid_rise && !flush && (dec_cnt == '0);
    // the write that fills the window triggers, as does every write after it
    assign trigger   = wrt_en && (full_q || (fill_cnt == WIN_M1));
    assign last_beat = (state == S_STREAM) && (beat_cnt == WIN_M1);

    // the address cycle reads the oldest slot straight from start_ptr;
    // streaming cycles walk rd_addr which was preloaded with start_ptr+1
    assign rd_sel = (state == S_ADDR) ? start_ptr : rd_addr;

    always_comb begin
        state_nxt = state;
        pend_nxt  = pending;
        ovr_set   = 1'b0;
        case (state)
            S_IDLE: begin
                if (trigger) begin
                    state_nxt = S_ADDR;
                end
            end
            S_ADDR: begin
                state_nxt = S_STREAM;
                if (trigger) begin
                    ovr_set  = pending;
                    pend_nxt = 1'b1;
                end
            end
            S_STREAM: begin
                if (last_beat) begin
                    // a trigger landing on the final beat is chained
                    // directly, just like one that was already pending
                    state_nxt = (pending || trigger) ? S_ADDR : S_IDLE;
                    pend_nxt  = 1'b0;
                    ovr_set   = pending && trigger;
                end else if (trigger) begin
                    ovr_set  = pending;
                    pend_nxt = 1'b1;
                end
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            pending   <= 1'b0;
            overrun_q <= 1'b0;
            full_q    <= 1'b0;
            dec_cnt   <= '0;
            wr_ptr    <= '0;
            fill_cnt  <= '0;
            start_ptr <= '0;
            rd_addr   <= '0;
            beat_cnt  <= '0;
        end else if (flush) begin
            state     <= S_IDLE;
            pending   <= 1'b0;
            overrun_q <= 1'b0;
            full_q    <= 1'b0;
            dec_cnt   <= '0;
            wr_ptr    <= '0;
            fill_cnt  <= '0;
            start_ptr <= '0;
            rd_addr   <= '0;
            beat_cnt  <= '0;
        end else begin
            state   <= state_nxt;
            pending <= pend_nxt;
            if (ovr_set) begin
                overrun_q <= 1'b1;
            end

            if (valid_rise) begin
                dec_cnt <= (dec_cnt == DEC_LAST) ? '0 : dec_cnt + DEC_W'(1);
            end

            if (wrt_en) begin
                wr_ptr <= wr_ptr + ONE_A;
                if (fill_cnt != WIN_A) begin
                    fill_cnt <= fill_cnt + ONE_A;
                end
                if (fill_cnt == WIN_M1) begin
                    full_q <= 1'b1;
                end
            end

            // every trigger, even a dropped one, re-aims the next burst so a
            // pending burst always covers the most recent write
            if (trigger) begin
                start_ptr <= wr_ptr + ONE_A - WIN_A;
            end

            case (state)
                S_ADDR: begin
                    rd_addr  <= start_ptr + ONE_A;
                    beat_cnt <= '0;
                end
                S_STREAM: begin
                    rd_addr  <= rd_addr + ONE_A;
                    beat_cnt <= beat_cnt + ONE_A;
                end
                default: begin
                    rd_addr  <= rd_addr;
                    beat_cnt <= beat_cnt;
                end
            endcase
        end
    end

    // sample storage; the slot being written is never inside the live window
    // because WINDOW is at most one less than the buffer depth
    always_ff @(posedge clk) begin
        if (wrt_en) begin
            mem[wr_ptr] <= new_smpl;
        end
        rd_data <= mem[rd_sel];
    end

    assign smpl_vld   = (state == S_STREAM);
    assign sequencing = (state != S_IDLE);
    assign seq_done   = last_beat;
    assign smpl_out   = smpl_vld ? rd_data : '0;
    assign full       = full_q;
    assign overrun    = overrun_q;

endmodule

// File: tb/tb_window_queue_mc.sv
// tb/tb_window_queue_mc.sv - scoreboard bench for window_queue_mc
module tb_window_queue_mc;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] a_new, b_new;
    logic        a_vr, b_vr, a_fl, b_fl;
    logic [31:0] a_out, b_out;
    logic        a_vld, a_seq, a_done, a_full, a_ovr;
    logic        b_vld, b_seq, b_done, b_full, b_ovr;

    int cyc    = 0;
    int n_chk  = 0;
    int n_fail = 0;

    typedef struct {
        logic [31:0] d;
        int          c;
        logic        last;
    } exp_t;

    exp_t qa[$];
    exp_t qb[$];
    exp_t ea, eb;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    window_queue_mc #(.WIDTH(16), .CHANNELS(2), .ADDR_W(4), .WINDOW(12), .DECIM(2)) dut_a (
        .clk(clk), .rst_n(rst_n), .new_smpl(a_new), .valid_rise(a_vr), .flush(a_fl),
        .smpl_out(a_out), .smpl_vld(a_vld), .sequencing(a_seq), .seq_done(a_done),
        .full(a_full), .overrun(a_ovr)
    );

    window_queue_mc #(.WIDTH(16), .CHANNELS(2), .ADDR_W(4), .WINDOW(12), .DECIM(1)) dut_b (
        .clk(clk), .rst_n(rst_n), .new_smpl(b_new), .valid_rise(b_vr), .flush(b_fl),
        .smpl_out(b_out), .smpl_vld(b_vld), .sequencing(b_seq), .seq_done(b_done),
        .full(b_full), .overrun(b_ovr)
    );

    // ch0 = v, ch1 = -v
    function automatic logic [31:0] pk(input int v);
        return {16'(-v), 16'(v)};
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
        n_chk++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: actual %0h required %0h at cycle %0d", nm, act, req, cyc);
        end
    endtask

    // monitors: pop an expected sample whenever the DUT presents one
    always @(negedge clk) begin
        if (a_vld) begin
            chk("a_sample_expected", qa.size() != 0, 1);
            if (qa.size() != 0) begin
                ea = qa.pop_front();
                chk("a_data", a_out, ea.d);
                chk("a_cycle", cyc, ea.c);
                chk("a_seq_done", a_done, ea.last);
                chk("a_sequencing", a_seq, 1);
            end
        end else begin
            chk("a_idle_out", a_out, 0);
            chk("a_idle_done", a_done, 0);
        end
    end

    always @(negedge clk) begin
        if (b_vld) begin
            chk("b_sample_expected", qb.size() != 0, 1);
            if (qb.size() != 0) begin
                eb = qb.pop_front();
                chk("b_data", b_out, eb.d);
                chk("b_cycle", cyc, eb.c);
                chk("b_seq_done", b_done, eb.last);
                chk("b_sequencing", b_seq, 1);
            end
        end else begin
            chk("b_idle_out", b_out, 0);
            chk("b_idle_done", b_done, 0);
        end
    end

    // window of cnt samples first, first+step, ...; entry 11 closes the burst
    task automatic push_win(input bit to_b, input int first, input int step, input int c0, input int cnt);
        for (int i = 0; i < cnt; i++) begin
            exp_t e;
            e.d    = pk(first + i * step);
            e.c    = c0 + i;
            e.last = (i == 11);
            if (to_b) qb.push_back(e);
            else      qa.push_back(e);
        end
    endtask

    // called and returns on a negedge; strobes are gap cycles apart
    task automatic strobe_a(input int v, input int gap);
        a_new = pk(v);
        a_vr  = 1'b1;
        @(negedge clk);
        a_vr  = 1'b0;
        repeat (gap - 1) @(negedge clk);
    endtask

    task automatic wait_idle_a();
        for (int i = 0; i < 60 && a_seq; i++) @(negedge clk);
        chk("a_idle_timeout", a_seq, 0);
        chk("a_queue_drained", qa.size(), 0);
    endtask

    // 24 strobes from a clean state: even offsets are written, the 12th
    // write (offset 22) triggers a burst of base, base+2, ..., base+22
    task automatic run_fill(input int base, input int gap);
        for (int j = 0; j < 24; j++) begin
            if (j == 22) push_win(1'b0, base, 2, cyc + 2, 12);
            strobe_a(base + j, gap);
            chk("a_full", a_full, j >= 22);
        end
        wait_idle_a();
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: actual running required finished at cycle %0d", cyc);
        $fatal(1);
    end

    initial begin
        int n;
        rst_n = 1'b0;
        a_new = '0; b_new = '0;
        a_vr = 1'b0; b_vr = 1'b0; a_fl = 1'b0; b_fl = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_a_out", a_out, 0);
        chk("rst_a_vld", a_vld, 0);
        chk("rst_a_seq", a_seq, 0);
        chk("rst_a_done", a_done, 0);
        chk("rst_a_full", a_full, 0);
        chk("rst_a_ovr", a_ovr, 0);
        chk("rst_b_seq", b_seq, 0);
        chk("rst_b_full", b_full, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // fill and first burst 0,2,...,22
        run_fill(0, 5);

        // further triggers, write and read pointers wrap past 15
        for (int k = 24; k < 36; k++) begin
            if (k % 2 == 0) push_win(1'b0, k - 22, 2, cyc + 2, 12);
            strobe_a(k, 16);
        end
        wait_idle_a();
        chk("a_overrun_clear", a_ovr, 0);

        // flush while the fifth sample of the burst for 36 is on the output
        n = cyc;
        push_win(1'b0, 14, 2, n + 2, 5);
        strobe_a(36, 1);
        repeat (5) @(negedge clk);
        a_fl = 1'b1;
        @(negedge clk);
        a_fl = 1'b0;
        chk("flush_seq", a_seq, 0);
        chk("flush_vld", a_vld, 0);
        chk("flush_out", a_out, 0);
        chk("flush_full", a_full, 0);
        chk("flush_queue", qa.size(), 0);
        run_fill(100, 3);

        // strobe coincident with flush must be discarded
        a_new = pk(999);
        a_vr  = 1'b1;
        a_fl  = 1'b1;
        @(negedge clk);
        a_vr  = 1'b0;
        a_fl  = 1'b0;
        @(negedge clk);
        run_fill(200, 3);

        // asynchronous reset during the third sample of the burst for 224
        n = cyc;
        push_win(1'b0, 202, 2, n + 2, 3);
        strobe_a(224, 1);
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_out", a_out, 0);
        chk("arst_vld", a_vld, 0);
        chk("arst_seq", a_seq, 0);
        chk("arst_done", a_done, 0);
        chk("arst_full", a_full, 0);
        chk("arst_ovr", a_ovr, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("arst_queue", qa.size(), 0);
        run_fill(300, 3);

        // DECIM=1: back-to-back triggers, pending then overrun
        n = 0;
        for (int i = 0; i < 14; i++) begin
            if (i == 11) begin
                n = cyc;
                push_win(1'b1, 0, 1, n + 2, 12);
                push_win(1'b1, 2, 1, n + 15, 12);
            end
            b_new = pk(i);
            b_vr  = 1'b1;
            @(negedge clk);
            if (i >= 11) chk("b_seq_start", b_seq, 1);
        end
        b_vr = 1'b0;
        while (cyc <= n + 26) begin
            chk("b_seq_no_gap", b_seq, 1);
            @(negedge clk);
        end
        chk("b_seq_end", b_seq, 0);
        chk("b_overrun_set", b_ovr, 1);
        chk("b_full", b_full, 1);
        chk("b_queue_drained", qb.size(), 0);
        b_fl = 1'b1;
        @(negedge clk);
        b_fl = 1'b0;
        chk("b_flush_ovr", b_ovr, 0);
        chk("b_flush_full", b_full, 0);
        repeat (2) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
